// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready handshakes: add/sub/logic in one step,
// shift-add multiply and restoring divide/remainder over WIDTH iterations on magnitudes.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             ze,
    output logic             ovf,
    output logic             dz,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_REM = 3'b010, OP_MUL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100, OP_OR  = 3'b101, OP_XOR = 3'b110, OP_DIV = 3'b111;
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       instr_q, instr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic             ze_q, ze_d, ovf_q, ovf_d, dz_q, dz_d, err_q, err_d;

    logic [2:0]         op_s;
    logic               sgn_s, neg_a_s, neg_b_s, slow_in_s;
    logic [WIDTH:0]     add_s, sub_s, mul_step_s, shl_s, trial_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        mag = (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign op_s       = instr_q[2:0];
    assign sgn_s      = instr_q[4];
    assign neg_a_s    = sgn_s & a_q[WIDTH-1];
    assign neg_b_s    = sgn_s & b_q[WIDTH-1];
    assign add_s      = {1'b0, a_q} + {1'b0, b_q};
    assign sub_s      = {1'b0, a_q} - {1'b0, b_q};
    // Multiply step: conditionally add multiplicand into the high half before the right shift.
    assign mul_step_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    assign shl_s      = {hi_q, lo_q[WIDTH-1]};
    assign trial_s    = shl_s - {1'b0, m_q};
    assign prod_s     = (neg_a_s ^ neg_b_s) ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_s      = (neg_a_s ^ neg_b_s) ? -lo_q : lo_q;
    assign rem_s      = neg_a_s ? -hi_q : hi_q;

    // Divide by zero and illegal ops take the single-step path through FIX.
    assign slow_in_s = !instr[3] && ((instr[2:0] == OP_MUL) ||
                       (((instr[2:0] == OP_DIV) || (instr[2:0] == OP_REM)) && (b != ZERO)));

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;
    assign ze        = ze_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;
    assign err       = err_q;

    // Next-state, datapath iteration and result formation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        ze_d     = ze_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    instr_d = instr;
                    a_d     = a;
                    b_d     = b;
                    hi_d    = ZERO;
                    cnt_d   = CW'(WIDTH - 1);
                    if (instr[2:0] == OP_MUL) begin
                        m_d  = mag(a, instr[4]);
                        lo_d = mag(b, instr[4]);
                    end else begin
                        m_d  = mag(b, instr[4]);
                        lo_d = mag(a, instr[4]);
                    end
                    state_d = slow_in_s ? S_BUSY : S_FIX;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (op_s == OP_MUL) begin
                    {hi_d, lo_d} = {mul_step_s, lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = trial_s[WIDTH] ? shl_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], ~trial_s[WIDTH]};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_FIX: begin
                res_lo_d = ZERO;
                res_hi_d = ZERO;
                ovf_d    = 1'b0;
                dz_d     = 1'b0;
                err_d    = 1'b0;
                if (instr_q[3]) begin
                    err_d = 1'b1;
                end else begin
                    case (op_s)
                        OP_ADD: begin
                            res_lo_d = add_s[WIDTH-1:0];
                            ovf_d    = sgn_s ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]))
                                             : add_s[WIDTH];
                        end
                        OP_SUB: begin
                            res_lo_d = sub_s[WIDTH-1:0];
                            ovf_d    = sgn_s ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_s[WIDTH-1] != a_q[WIDTH-1]))
                                             : sub_s[WIDTH];
                        end
                        OP_AND: res_lo_d = a_q & b_q;
                        OP_OR:  res_lo_d = a_q | b_q;
                        OP_XOR: res_lo_d = a_q ^ b_q;
                        OP_MUL: begin
                            res_lo_d = prod_s[WIDTH-1:0];
                            res_hi_d = prod_s[2*WIDTH-1:WIDTH];
                            ovf_d    = sgn_s ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                                             : (prod_s[2*WIDTH-1:WIDTH] != ZERO);
                        end
                        OP_DIV, OP_REM: begin
                            if (b_q == ZERO) begin
                                dz_d     = 1'b1;
                                res_lo_d = (op_s == OP_DIV) ? ONES : a_q;
                                res_hi_d = (op_s == OP_DIV) ? a_q : ONES;
                            end else begin
                                // MIN / -1 already yields quotient MIN and remainder 0 from the magnitudes.
                                res_lo_d = (op_s == OP_DIV) ? quo_s : rem_s;
                                res_hi_d = (op_s == OP_DIV) ? rem_s : quo_s;
                                ovf_d    = sgn_s && (a_q == MIN) && (b_q == ONES);
                            end
                        end
                        default: res_lo_d = ZERO;
                    endcase
                end
                ze_d    = (res_lo_d == ZERO);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            instr_q  <= 5'b00000;
            a_q      <= ZERO;
            b_q      <= ZERO;
            m_q      <= ZERO;
            hi_q     <= ZERO;
            lo_q     <= ZERO;
            res_lo_q <= ZERO;
            res_hi_q <= ZERO;
            ze_q     <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            ze_q     <= ze_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, in_ready, out_valid, ze, ovf, dz, err;
    logic [31:0] a, b, res_lo, res_hi;
    logic [4:0]  instr;
    logic        in_valid8, out_ready8, in_ready8, out_valid8, ze8, ovf8, dz8, err8;
    logic [7:0]  a8, b8, res_lo8, res_hi8;
    logic [4:0]  instr8;
    int          nchk = 0;
    int          nerr = 0;
    int          stray;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .res_lo(res_lo), .res_hi(res_hi), .ze(ze), .ovf(ovf), .dz(dz), .err(err)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .instr(instr8), .out_valid(out_valid8), .out_ready(out_ready8),
        .res_lo(res_lo8), .res_hi(res_hi8), .ze(ze8), .ovf(ovf8), .dz(dz8), .err(err8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags are {ze, ovf, dz, err}; hold = cycles of backpressure before consuming
    task automatic op32(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                        input logic [4:0] ti, input int lat_exp, input logic [31:0] lo_exp,
                        input logic [31:0] hi_exp, input logic [3:0] fl_exp, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 64'd1);
        a = ta; b = tb2; instr = ti; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; instr = 5'b00000;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, lat_exp);
        chk({tag, "_res_lo"}, res_lo, lo_exp);
        chk({tag, "_res_hi"}, res_hi, hi_exp);
        chk({tag, "_flags"}, {ze, ovf, dz, err}, fl_exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = ((i % 2) == 0); a = 32'd7; b = 32'd1; instr = 5'b00000;
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 64'd1);
            chk({tag, "_hold_ready"}, in_ready, 64'd0);
            chk({tag, "_hold_lo"}, res_lo, lo_exp);
            chk({tag, "_hold_flags"}, {ze, ovf, dz, err}, fl_exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_consumed"}, out_valid, 64'd0);
        chk({tag, "_ready_back"}, in_ready, 64'd1);
    endtask

    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb2,
                       input logic [4:0] ti, input int lat_exp, input logic [7:0] lo_exp,
                       input logic [7:0] hi_exp, input logic [3:0] fl_exp);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready8, 64'd1);
        a8 = ta; b8 = tb2; instr8 = ti; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; instr8 = 5'b00000;
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, lat_exp);
        chk({tag, "_res_lo"}, res_lo8, lo_exp);
        chk({tag, "_res_hi"}, res_hi8, hi_exp);
        chk({tag, "_flags"}, {ze8, ovf8, dz8, err8}, fl_exp);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        chk({tag, "_consumed"}, out_valid8, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0; instr = 5'b00000;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'd0; b8 = 8'd0; instr8 = 5'b00000;
        #12;
        chk("rst_in_ready", in_ready, 64'd1);
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_res", {res_hi, res_lo}, 64'd0);
        chk("rst_flags", {ze, ovf, dz, err}, 64'd0);
        chk("rst8_state", {in_ready8, out_valid8}, 64'd2);
        chk("rst8_res", {res_hi8, res_lo8, ze8, ovf8, dz8, err8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op32("add",        32'd5,          32'd2,          5'b00000, 1,  32'd7,          32'd0,          4'b0000, 0);
        op32("sub_hold",   32'd3,          32'd3,          5'b00001, 1,  32'd0,          32'd0,          4'b1000, 10);
        op32("usub_brw",   32'd2,          32'd3,          5'b00001, 1,  32'hFFFF_FFFF,  32'd0,          4'b0100, 0);
        op32("ssub",       32'd2,          32'd3,          5'b10001, 1,  32'hFFFF_FFFF,  32'd0,          4'b0000, 0);
        op32("sadd_ovf",   32'h7FFF_FFFF,  32'd1,          5'b10000, 1,  32'h8000_0000,  32'd0,          4'b0100, 0);
        op32("uadd_cry",   32'hFFFF_FFFF,  32'd1,          5'b00000, 1,  32'd0,          32'd0,          4'b1100, 0);
        op32("and",        32'hF0F0_F0F0,  32'hFF00_FF00,  5'b00100, 1,  32'hF000_F000,  32'd0,          4'b0000, 0);
        op32("or",         32'hF0F0_F0F0,  32'hFF00_FF00,  5'b00101, 1,  32'hFFF0_FFF0,  32'd0,          4'b0000, 0);
        op32("xor",        32'hF0F0_F0F0,  32'hFF00_FF00,  5'b00110, 1,  32'h0FF0_0FF0,  32'd0,          4'b0000, 0);
        op32("smul",       32'hFFFF_FFFB,  32'hFFFF_FFFE,  5'b10011, 33, 32'd10,         32'd0,          4'b0000, 0);
        op32("smul_ovf",   32'h7FFF_FFFF,  32'd2,          5'b10011, 33, 32'hFFFF_FFFE,  32'd0,          4'b0100, 0);
        op32("smul_neg",   32'hFFFF_FFFD,  32'd4,          5'b10011, 33, 32'hFFFF_FFF4,  32'hFFFF_FFFF,  4'b0000, 0);
        op32("umul",       32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'b00011, 33, 32'h0000_0001,  32'hFFFF_FFFE,  4'b0100, 0);
        op32("sdiv",       32'hFFFF_FFFB,  32'hFFFF_FFFE,  5'b10111, 33, 32'd2,          32'hFFFF_FFFF,  4'b0000, 0);
        op32("srem",       32'hFFFF_FFFB,  32'hFFFF_FFFE,  5'b10010, 33, 32'hFFFF_FFFF,  32'd2,          4'b0000, 0);
        op32("sdiv_min",   32'h8000_0000,  32'hFFFF_FFFF,  5'b10111, 33, 32'h8000_0000,  32'd0,          4'b0100, 0);
        op32("sdiv_mix",   32'd7,          32'hFFFF_FFFE,  5'b10111, 33, 32'hFFFF_FFFD,  32'd1,          4'b0000, 0);
        op32("udiv",       32'd100,        32'd7,          5'b00111, 33, 32'd14,         32'd2,          4'b0000, 0);
        op32("float",      32'd5,          32'd2,          5'b01000, 1,  32'd0,          32'd0,          4'b1001, 0);
        op32("float_mul",  32'd5,          32'd2,          5'b11011, 1,  32'd0,          32'd0,          4'b1001, 0);
        op32("udiv_dz",    32'd9,          32'd0,          5'b00111, 1,  32'hFFFF_FFFF,  32'd9,          4'b0010, 0);
        op32("urem_dz",    32'd9,          32'd0,          5'b00010, 1,  32'd9,          32'hFFFF_FFFF,  4'b0010, 0);

        // abandon a divide partway through its iterations
        @(negedge clk);
        a = 32'd100; b = 32'd7; instr = 5'b00111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 64'd1);
        chk("midrst_out_valid", out_valid, 64'd0);
        chk("midrst_res", {res_hi, res_lo}, 64'd0);
        chk("midrst_flags", {ze, ovf, dz, err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("midrst_no_stale", stray, 64'd0);
        chk("midrst_ready", in_ready, 64'd1);
        op32("add_after", 32'd1, 32'd1, 5'b00000, 1, 32'd2, 32'd0, 4'b0000, 0);

        op8("smul8",     8'hFB, 8'hFE, 5'b10011, 9, 8'h0A, 8'h00, 4'b0000);
        op8("smul8_ovf", 8'h7F, 8'h02, 5'b10011, 9, 8'hFE, 8'h00, 4'b0100);
        op8("umul8",     8'hFF, 8'hFF, 5'b00011, 9, 8'h01, 8'hFE, 4'b0100);
        op8("sdiv8",     8'hFB, 8'hFE, 5'b10111, 9, 8'h02, 8'hFF, 4'b0000);
        op8("srem8",     8'hFB, 8'hFE, 5'b10010, 9, 8'hFF, 8'h02, 4'b0000);
        op8("sdiv8_min", 8'h80, 8'hFF, 5'b10111, 9, 8'h80, 8'h00, 4'b0100);
        op8("udiv8_dz",  8'h09, 8'h00, 5'b00111, 1, 8'hFF, 8'h09, 4'b0010);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
